pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline. Drives the D-stage register write enable (wpcir), bubbles the

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: D/E/M register usage in, stall/forward/MDU control out.
// The pipeline side is the master, the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             d_is_branch;
    logic             d_is_mdu;
    logic             e_wreg;
    logic             e_m2reg;
    logic [4:0]       e_rn;
    logic             m_wreg;
    logic             m_m2reg;
    logic [4:0]       m_rn;
    logic             mdu_done;
    logic             wpcir;
    logic             e_bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             mdu_start;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_use_rs, d_use_rt, d_is_branch, d_is_mdu,
        output e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn, mdu_done,
        input  wpcir, e_bubble, fwda, fwdb, mdu_start, mdu_err, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_use_rs, d_use_rt, d_is_branch, d_is_mdu,
        input  e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn, mdu_done,
        output wpcir, e_bubble, fwda, fwdb, mdu_start, mdu_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use and branch interlocks, D-stage forwarding,
// multi-cycle mul/div sequencing with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MDU_MAX_CYC = 40,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int                MCNT_W    = $clog2(MDU_MAX_CYC + 1);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MDU_MAX_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic wr, input logic [4:0] rn, input logic [4:0] r);
        return wr & (rn != 5'd0) & (rn == r);
    endfunction

    // An E-stage load has no value yet; falling through lets an older M producer win.
    function automatic logic [1:0] fwd_sel(input logic e_hit, input logic e_load,
                                           input logic m_hit, input logic m_load);
        logic [1:0] sel;
        if (e_hit && !e_load) begin
            sel = 2'b01;
        end else if (m_hit) begin
            sel = m_load ? 2'b11 : 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [MCNT_W-1:0] mcnt_r, mcnt_nxt_s;
    logic              mdu_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic e_hit_rs_s, e_hit_rt_s, m_hit_rs_s, m_hit_rt_s;
    logic load_use_s, br_haz_s, data_stall_s;
    logic wpcir_s, e_bubble_s, mdu_start_s, err_set_s;
    logic [1:0] fwda_s, fwdb_s;

    // Producer matches, interlock conditions and forwarding selects.
    always_comb begin
        e_hit_rs_s   = reg_hit(bus.e_wreg, bus.e_rn, bus.d_rs);
        e_hit_rt_s   = reg_hit(bus.e_wreg, bus.e_rn, bus.d_rt);
        m_hit_rs_s   = reg_hit(bus.m_wreg, bus.m_rn, bus.d_rs);
        m_hit_rt_s   = reg_hit(bus.m_wreg, bus.m_rn, bus.d_rt);
        load_use_s   = bus.e_m2reg & ((bus.d_use_rs & e_hit_rs_s) | (bus.d_use_rt & e_hit_rt_s));
        br_haz_s     = bus.d_is_branch & (e_hit_rs_s | e_hit_rt_s |
                                          (bus.m_m2reg & (m_hit_rs_s | m_hit_rt_s)));
        data_stall_s = load_use_s | br_haz_s;
        if (reset) begin
            fwda_s = 2'b00;
            fwdb_s = 2'b00;
        end else begin
            fwda_s = fwd_sel(e_hit_rs_s, bus.e_m2reg, m_hit_rs_s, bus.m_m2reg);
            fwdb_s = fwd_sel(e_hit_rt_s, bus.e_m2reg, m_hit_rt_s, bus.m_m2reg);
        end
    end

    // MDU sequencer next state and stall/launch outputs.
    always_comb begin
        state_nxt_s = state_r;
        mcnt_nxt_s  = mcnt_r;
        wpcir_s     = 1'b1;
        e_bubble_s  = 1'b0;
        mdu_start_s = 1'b0;
        err_set_s   = 1'b0;
        if (reset) begin
            state_nxt_s = ST_IDLE;
            mcnt_nxt_s  = '0;
            wpcir_s     = 1'b0;
            e_bubble_s  = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (data_stall_s) begin
                        wpcir_s    = 1'b0;
                        e_bubble_s = 1'b1;
                    end else if (bus.d_is_mdu) begin
                        mdu_start_s = 1'b1;
                        wpcir_s     = 1'b0;
                        e_bubble_s  = 1'b1;
                        mcnt_nxt_s  = '0;
                        state_nxt_s = ST_MDU_BUSY;
                    end else begin
                        wpcir_s = 1'b1;
                    end
                end
                ST_MDU_BUSY: begin
                    if (bus.mdu_done || (mcnt_r == MCNT_LAST)) begin
                        err_set_s   = ~bus.mdu_done;
                        mcnt_nxt_s  = '0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        wpcir_s    = 1'b0;
                        e_bubble_s = 1'b1;
                        mcnt_nxt_s = mcnt_r + MCNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    mcnt_nxt_s  = '0;
                end
            endcase
        end
    end

    // State, busy counter, sticky timeout flag and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mcnt_r      <= '0;
            mdu_err_r   <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            mcnt_r    <= mcnt_nxt_s;
            mdu_err_r <= mdu_err_r | err_set_s;
            if (!wpcir_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign bus.wpcir     = wpcir_s;
    assign bus.e_bubble  = e_bubble_s;
    assign bus.mdu_start = mdu_start_s;
    assign bus.fwda      = fwda_s;
    assign bus.fwdb      = fwdb_s;
    assign bus.mdu_err   = mdu_err_r;
    assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl: stimulus pushes reference-model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;
    localparam int MAXC   = 40;
    localparam int CW     = 4;
    localparam int CNT_TOP = (1 << CW) - 1;

    typedef struct packed {
        logic          wpcir;
        logic          e_bubble;
        logic          mdu_start;
        logic [1:0]    fwda;
        logic [1:0]    fwdb;
        logic          mdu_err;
        logic [CW-1:0] stall_cnt;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    // reference state
    bit m_busy;
    int m_busy_n;
    bit m_err;
    int m_cnt;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MDU_MAX_CYC(MAXC), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit hit(input bit wr, input int rn, input int r);
        return wr && (rn != 0) && (rn == r);
    endfunction

    function automatic int fwd_model(input int r);
        if (hit(bus.e_wreg, bus.e_rn, r) && !bus.e_m2reg) return 1;
        if (hit(bus.m_wreg, bus.m_rn, r)) return bus.m_m2reg ? 3 : 2;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // mode 0 random, 1 held load-use, 2 MDU op with no completion, 3 quiet
    task automatic step(input bit rst, input int mode);
        exp_t e;
        bit   lu, bh, stall;
        @(posedge clock);
        #1;
        reset = rst;
        case (mode)
            1: begin
                bus.e_wreg = 1'b1; bus.e_m2reg = 1'b1; bus.e_rn = 5'd5;
                bus.d_rs = 5'd5; bus.d_use_rs = 1'b1; bus.d_rt = 5'd0; bus.d_use_rt = 1'b0;
                bus.m_wreg = 1'b0; bus.m_m2reg = 1'b0; bus.m_rn = 5'd0;
                bus.d_is_branch = 1'b0; bus.d_is_mdu = 1'b0; bus.mdu_done = 1'b0;
            end
            2, 3: begin
                bus.e_wreg = 1'b0; bus.e_m2reg = 1'b0; bus.e_rn = 5'd0;
                bus.m_wreg = 1'b0; bus.m_m2reg = 1'b0; bus.m_rn = 5'd0;
                bus.d_rs = 5'd1; bus.d_rt = 5'd2; bus.d_use_rs = 1'b1; bus.d_use_rt = 1'b1;
                bus.d_is_branch = 1'b0; bus.d_is_mdu = (mode == 2); bus.mdu_done = 1'b0;
            end
            default: begin
                bus.d_rs = 5'($urandom_range(0, 7)); bus.d_rt = 5'($urandom_range(0, 7));
                bus.d_use_rs = 1'($urandom); bus.d_use_rt = 1'($urandom);
                bus.d_is_branch = ($urandom_range(0, 3) == 0);
                bus.d_is_mdu = ($urandom_range(0, 7) == 0);
                bus.e_wreg = 1'($urandom); bus.e_m2reg = 1'($urandom); bus.e_rn = 5'($urandom_range(0, 7));
                bus.m_wreg = 1'($urandom); bus.m_m2reg = 1'($urandom); bus.m_rn = 5'($urandom_range(0, 7));
                bus.mdu_done = ($urandom_range(0, 6) == 0);
            end
        endcase
        #1;
        lu = bus.e_m2reg && ((bus.d_use_rs && hit(bus.e_wreg, bus.e_rn, bus.d_rs)) ||
                             (bus.d_use_rt && hit(bus.e_wreg, bus.e_rn, bus.d_rt)));
        bh = bus.d_is_branch && (hit(bus.e_wreg, bus.e_rn, bus.d_rs) || hit(bus.e_wreg, bus.e_rn, bus.d_rt) ||
             (bus.m_m2reg && (hit(bus.m_wreg, bus.m_rn, bus.d_rs) || hit(bus.m_wreg, bus.m_rn, bus.d_rt))));
        stall = lu || bh;
        e.mdu_err   = m_err;
        e.stall_cnt = CW'(m_cnt);
        e.mdu_start = 1'b0;
        e.fwda      = 2'(fwd_model(bus.d_rs));
        e.fwdb      = 2'(fwd_model(bus.d_rt));
        e.wpcir     = 1'b1;
        if (rst) begin
            e.wpcir = 1'b0; e.fwda = 2'b00; e.fwdb = 2'b00;
            m_busy = 1'b0; m_busy_n = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (!m_busy) begin
                if (stall) begin
                    e.wpcir = 1'b0;
                end else if (bus.d_is_mdu) begin
                    e.wpcir = 1'b0; e.mdu_start = 1'b1; m_busy = 1'b1; m_busy_n = 0;
                end
            end else begin
                m_busy_n++;
                if (bus.mdu_done) begin
                    m_busy = 1'b0;
                end else if (m_busy_n == MAXC) begin
                    m_busy = 1'b0; m_err = 1'b1;
                end else begin
                    e.wpcir = 1'b0;
                end
            end
            if (!e.wpcir && m_cnt < CNT_TOP) m_cnt++;
        end
        e.e_bubble = ~e.wpcir;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every cycle with a pending prediction is compared mid-cycle.
    always @(negedge clock) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("wpcir",     int'(bus.wpcir),     int'(x.wpcir));
            check("e_bubble",  int'(bus.e_bubble),  int'(x.e_bubble));
            check("mdu_start", int'(bus.mdu_start), int'(x.mdu_start));
            check("fwda",      int'(bus.fwda),      int'(x.fwda));
            check("fwdb",      int'(bus.fwdb),      int'(x.fwdb));
            check("mdu_err",   int'(bus.mdu_err),   int'(x.mdu_err));
            check("stall_cnt", int'(bus.stall_cnt), int'(x.stall_cnt));
        end
    end

    initial begin
        n_checks = 0; n_fail = 0;
        m_busy = 1'b0; m_busy_n = 0; m_err = 1'b0; m_cnt = 0;
        reset = 1'b1;
        bus.d_rs = 5'd0; bus.d_rt = 5'd0; bus.d_use_rs = 1'b0; bus.d_use_rt = 1'b0;
        bus.d_is_branch = 1'b0; bus.d_is_mdu = 1'b0; bus.e_wreg = 1'b0; bus.e_m2reg = 1'b0;
        bus.e_rn = 5'd0; bus.m_wreg = 1'b0; bus.m_m2reg = 1'b0; bus.m_rn = 5'd0; bus.mdu_done = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 3);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 49) == 0, 0);
        step(1'b1, 3);
        for (int i = 0; i < 20; i++) step(1'b0, 1);
        for (int i = 0; i < 2; i++) step(1'b0, 3);
        for (int i = 0; i < 50; i++) step(1'b0, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 3);
        for (int i = 0; i < 5; i++) step(1'b0, 2);
        step(1'b1, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 3);
        for (int i = 0; i < 200; i++) step($urandom_range(0, 49) == 0, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        check("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
